alu_result_collector: RTL and testbench
=======================================

Name: alu_result_collector

Overview:
- Downstream stage of the 4-bit ALU. Samples each valid ALU result with its flags and op code, and packs them into a 9-bit record.
- Records are buffered in a small FWFT FIFO and drained to the trace/compare logic over a valid/ready handshake.
- Keeps a sticky consistency check of the zero flag against the result, plus drop accounting. Together these give the Trojan-detection flow a lossless or loss-accounted result stream.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of FIFO, counters and sticky flags
- in_valid  input  1  ALU outputs valid this cycle
- in_op  input  2  op code that produced the sample
- in_result  input  4  ALU result
- in_carry  input  1  ALU carry
- in_zero  input  1  ALU zero
- in_overflow  input  1  ALU overflow
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_data  output  9  {op[1:0], overflow, zero, carry, result[3:0]}
- level  output  clog2(DEPTH)+1  current occupancy
- drop_cnt  output  DROP_W  saturating count of lost samples
- dropped  output  1  sticky: at least one sample lost
- flag_err  output  1  sticky: zero flag inconsistent with result

Behaviour:
- Reset (rst_n low, async):
  - Pointers, level, drop_cnt, dropped and flag_err go to 0.
  - out_valid is 0; out_data is 0.
  - Reset mid-stream discards all buffered records.
- pop = out_valid & out_ready.
- push_req = in_valid.
- push = push_req & (level < DEPTH | pop): a simultaneous pop frees the slot in the same cycle.
- On push: the record is written at the write pointer, and the pointer wraps modulo DEPTH.
- On pop: the read pointer advances with wrap.
- Level update:
  - level += push - pop each cycle.
  - push & pop together leave level unchanged.
  - At level == 0, pop is impossible because out_valid = 0.
- FWFT output:
  - out_valid = (level != 0).
  - out_data = entry at the read pointer, held stable while out_valid & !out_ready.
  - Latency: a record pushed at edge N appears on out_data/out_valid after edge N (visible in cycle N+1).
  - No bypass combinational path from inputs to outputs.
- Drop:
  - A drop occurs when push_req & !push, i.e. the FIFO is full and there is no pop.
  - On a drop, drop_cnt increments, saturating at 2^DROP_W-1, and dropped is set.
  - A dropped sample is not checked for flag_err.
- flag_err:
  - Set on any accepted push where in_zero != (in_result == 4'h0).
  - Sticky until clear or reset.
- clear:
  - Sets pointers, level, drop_cnt, dropped and flag_err to 0 at the next edge.
  - Has priority over push and pop in the same cycle; the sample offered that cycle is discarded and not counted as a drop.
- Only the stored record is forwarded; no ALU arithmetic is recomputed.

Optional Feature:
- Macro FLAG_STATS_EN.
- When defined, adds outputs carry_cnt, zero_cnt and ovf_cnt, each 16-bit.
  - Each counter saturates at 16'hFFFF.
  - Each increments on accepted pushes whose corresponding flag is 1.
  - All three are cleared by reset and by clear.
- When undefined, these ports and registers are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_mon_pkg holds:
  - the record width constant (9) and field offsets (RES_LSB=0, CARRY=4, ZERO=5, OVF=6, OP_LSB=7);
  - the op enumeration matching the ALU's 2-bit op encoding;
  - the saturating-increment helper function.
- One sub-module, alu_rec_fifo: a parameterised DEPTH x 9 FWFT FIFO with push, pop, level, full and empty.
- The collector wraps the FIFO and adds drop, flag-check and stats logic.

Test Plan:
- Reset then single push: A-result 4'h5, carry 1, op 2'b01 -> out_valid=1 next cycle, out_data=9'b01_0_0_1_0101, level=1; pop -> level=0, out_valid=0.
- Fill with out_ready=0: 10 consecutive valid samples, DEPTH=8 -> level=8, drop_cnt=2, dropped=1. Drain yields the first 8 records in order, with pointer wrap verified on a second fill.
- Full with simultaneous push and pop: level=8, in_valid=1, out_ready=1 -> level stays 8, drop_cnt unchanged, new record appears at the tail.
- Zero-flag check:
  - result 4'h0, zero 0 -> flag_err=1 and stays set.
  - result 4'h3, zero 0 on a fresh run -> flag_err=0.
  - result 4'h0, zero 1 on a fresh run -> flag_err=0.
- Clear and async reset mid-stream:
  - clear with in_valid=1 at level 5 -> level=0, drop_cnt=0, dropped=0, flag_err=0, no record stored.
  - rst_n low asynchronously at level 3 -> outputs 0 immediately, before the next clk edge.
- FLAG_STATS_EN defined: 4 accepted pushes with carry set on 3 of them and overflow on 1, plus 1 dropped push with carry set -> carry_cnt=3, ovf_cnt=1.

Source files
------------

// File: rtl/alu_mon_pkg.sv
// Shared definitions for the ALU result monitor: record layout, op codes, helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_mon_pkg;

  // Record layout: {op[1:0], overflow, zero, carry, result[3:0]}
  localparam int REC_W   = 9;
  localparam int RES_LSB = 0;
  localparam int CARRY   = 4;
  localparam int ZERO    = 5;
  localparam int OVF     = 6;
  localparam int OP_LSB  = 7;

  // Op encoding as issued by the 4-bit ALU
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  // Increment that sticks at max_val; callers truncate back to their own width
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/alu_result_collector_if.sv
// ALU sample input bundle plus the record stream towards the trace/compare logic.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready handshake on the record side; input side has none.
interface alu_result_collector_if;
  import alu_mon_pkg::*;

  logic             in_valid;
  logic [1:0]       in_op;
  logic [3:0]       in_result;
  logic             in_carry;
  logic             in_zero;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [REC_W-1:0] out_data;

  // Producer of samples and consumer of records
  modport master (
    output in_valid, in_op, in_result, in_carry, in_zero, in_overflow, out_ready,
    input  out_valid, out_data
  );

  // The collector itself
  modport slave (
    input  in_valid, in_op, in_result, in_carry, in_zero, in_overflow, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/alu_rec_fifo.sv
// DEPTH x REC_W first-word-fall-through FIFO for ALU records.
// Latency: a record pushed at edge N is visible on rd_dat from cycle N+1.
// Backpressure: push ignored when full unless popping; pop ignored when empty; clear wins.
module alu_rec_fifo
  import alu_mon_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [REC_W-1:0] wr_dat,
  input  logic             pop,
  output logic [REC_W-1:0] rd_dat,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointer and occupancy next state; pointers wrap naturally as DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because the read side is masked when empty
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];
  assign level  = level_q;

endmodule

// File: rtl/alu_result_collector.sv
// Packs valid ALU samples into records, buffers them FWFT, counts drops, checks zero flag.
// Latency: sample accepted at edge N is on out_data/out_valid from cycle N+1; no comb input->output path.
// Backpressure: out_valid/out_ready; a sample arriving while full with no pop is dropped and counted.
// Optional FLAG_STATS_EN adds saturating 16-bit carry/zero/overflow counters of accepted samples.
module alu_result_collector
  import alu_mon_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter int  DROP_W = 8,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  alu_result_collector_if.slave alu,
  output logic [LVL_W-1:0]     level,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic                 dropped,
  output logic                 flag_err
`ifdef FLAG_STATS_EN
  ,
  output logic [15:0]          carry_cnt,
  output logic [15:0]          zero_cnt,
  output logic [15:0]          ovf_cnt
`endif
);

  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;
  logic             zero_mismatch;
  logic [REC_W-1:0] rec;
  logic [REC_W-1:0] head;

  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              dropped_q, dropped_d;
  logic              flag_err_q, flag_err_d;

  assign pop  = alu.out_valid & alu.out_ready;
  // A pop in the same cycle frees the slot for the incoming sample
  assign push = alu.in_valid & (~full | pop) & ~clear;
  assign drop = alu.in_valid & full & ~pop & ~clear;
  assign zero_mismatch = alu.in_zero != (alu.in_result == 4'h0);

  // Assemble the record from the raw sample fields
  always_comb begin
    rec                  = '0;
    rec[RES_LSB +: 4]    = alu.in_result;
    rec[CARRY]           = alu.in_carry;
    rec[ZERO]            = alu.in_zero;
    rec[OVF]             = alu.in_overflow;
    rec[OP_LSB +: 2]     = alu.in_op;
  end

  alu_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .push   (push),
    .wr_dat (rec),
    .pop    (pop),
    .rd_dat (head),
    .level  (level),
    .full   (full),
    .empty  (empty)
  );

  assign alu.out_valid = ~empty;
  assign alu.out_data  = head;

  // Drop accounting and sticky zero-flag check; dropped samples are never flag-checked
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    dropped_d  = dropped_q;
    flag_err_d = flag_err_q;
    if (clear) begin
      drop_cnt_d = '0;
      dropped_d  = 1'b0;
      flag_err_d = 1'b0;
    end else begin
      if (drop) begin
        drop_cnt_d = DROP_W'(sat_inc(32'(drop_cnt_q), 32'({DROP_W{1'b1}})));
        dropped_d  = 1'b1;
      end
      if (push && zero_mismatch) flag_err_d = 1'b1;
    end
  end

  // Status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      dropped_q  <= 1'b0;
      flag_err_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      dropped_q  <= dropped_d;
      flag_err_q <= flag_err_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign dropped  = dropped_q;
  assign flag_err = flag_err_q;

`ifdef FLAG_STATS_EN
  logic [15:0] carry_cnt_q, carry_cnt_d;
  logic [15:0] zero_cnt_q,  zero_cnt_d;
  logic [15:0] ovf_cnt_q,   ovf_cnt_d;

  // Flag population counts over accepted samples only
  always_comb begin
    carry_cnt_d = carry_cnt_q;
    zero_cnt_d  = zero_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    if (clear) begin
      carry_cnt_d = '0;
      zero_cnt_d  = '0;
      ovf_cnt_d   = '0;
    end else if (push) begin
      if (alu.in_carry)    carry_cnt_d = 16'(sat_inc(32'(carry_cnt_q), 32'hFFFF));
      if (alu.in_zero)     zero_cnt_d  = 16'(sat_inc(32'(zero_cnt_q),  32'hFFFF));
      if (alu.in_overflow) ovf_cnt_d   = 16'(sat_inc(32'(ovf_cnt_q),   32'hFFFF));
    end
  end

  // Flag counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
      zero_cnt_q  <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      carry_cnt_q <= carry_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign carry_cnt = carry_cnt_q;
  assign zero_cnt  = zero_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Randomised and directed bench for alu_result_collector against a queue-based reference model.
// Latency: checks every output 1 time unit after each rising clk edge.
// Backpressure: drives out_ready directly; full/drop behaviour modelled by queue capacity.
module tb_alu_result_collector;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic [LVL_W-1:0]  level;
  logic [DROP_W-1:0] drop_cnt;
  logic              dropped;
  logic              flag_err;
`ifdef FLAG_STATS_EN
  logic [15:0]       carry_cnt, zero_cnt, ovf_cnt;
`endif

  alu_result_collector_if alu_if ();

  alu_result_collector #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .alu      (alu_if),
    .level    (level),
    .drop_cnt (drop_cnt),
    .dropped  (dropped),
    .flag_err (flag_err)
`ifdef FLAG_STATS_EN
    ,
    .carry_cnt(carry_cnt),
    .zero_cnt (zero_cnt),
    .ovf_cnt  (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [8:0] mq[$];
  int         m_drop;
  bit         m_dropped;
  bit         m_ferr;
  int         m_carry, m_zero, m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop = 0; m_dropped = 0; m_ferr = 0;
    m_carry = 0; m_zero = 0; m_ovf = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(alu_if.out_valid), 32'(mq.size() != 0));
    chk({tag, ".out_data"},  32'(alu_if.out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    chk({tag, ".level"},     32'(level),    32'(mq.size()));
    chk({tag, ".drop_cnt"},  32'(drop_cnt), 32'(m_drop));
    chk({tag, ".dropped"},   32'(dropped),  32'(m_dropped));
    chk({tag, ".flag_err"},  32'(flag_err), 32'(m_ferr));
`ifdef FLAG_STATS_EN
    chk({tag, ".carry_cnt"}, 32'(carry_cnt), 32'(m_carry));
    chk({tag, ".zero_cnt"},  32'(zero_cnt),  32'(m_zero));
    chk({tag, ".ovf_cnt"},   32'(ovf_cnt),   32'(m_ovf));
`endif
  endtask

  // One clock cycle: drive inputs, advance model, check outputs after the edge
  task automatic step(input string tag, input logic v, input logic [1:0] op, input logic [3:0] res,
                      input logic c, input logic z, input logic o, input logic rdy, input logic clr);
    bit pop_e;
    alu_if.in_valid = v;  alu_if.in_op = op; alu_if.in_result = res;
    alu_if.in_carry = c;  alu_if.in_zero = z; alu_if.in_overflow = o;
    alu_if.out_ready = rdy; clear = clr;
    pop_e = (mq.size() != 0) && rdy;
    if (clr) begin
      model_reset();
    end else begin
      if (pop_e) void'(mq.pop_front());
      if (v) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({op, o, z, c, res});
          if (z != (res == 4'h0)) m_ferr = 1;
          if (c) m_carry = (m_carry < 16'hFFFF) ? m_carry + 1 : m_carry;
          if (z) m_zero  = (m_zero  < 16'hFFFF) ? m_zero  + 1 : m_zero;
          if (o) m_ovf   = (m_ovf   < 16'hFFFF) ? m_ovf   + 1 : m_ovf;
        end else begin
          m_drop = (m_drop < DROP_MAX) ? m_drop + 1 : m_drop;
          m_dropped = 1;
        end
      end
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic rdy);
    step(tag, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Consistent random sample pushed with a given ready
  task automatic push_rand(input string tag, input logic rdy);
    logic [3:0] r;
    r = 4'($urandom);
    step(tag, 1'b1, 2'($urandom), r, 1'($urandom), (r == 4'h0), 1'($urandom), rdy, 1'b0);
  endtask

  task automatic do_reset();
    alu_if.in_valid = 0; alu_if.in_op = 0; alu_if.in_result = 0;
    alu_if.in_carry = 0; alu_if.in_zero = 0; alu_if.in_overflow = 0;
    alu_if.out_ready = 0; clear = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    #2;
    do_reset();

    // Single push then pop
    step("single_push", 1'b1, 2'b01, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_rec", 32'(alu_if.out_data), 32'h095);
    chk("single_lvl", 32'(level), 32'd1);
    idle("single_pop", 1'b1);
    chk("single_empty", 32'(alu_if.out_valid), 32'd0);

    // Overfill with no drain, then drain; repeated to wrap the pointers
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) push_rand("fill", 1'b0);
      chk("fill_level", 32'(level), 32'd8);
      chk("fill_drops", 32'(drop_cnt), 32'(2 * (pass + 1)));
      for (int i = 0; i < 8; i++) idle("drain", 1'b1);
    end

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) push_rand("full_fill", 1'b0);
    step("full_pp", 1'b1, 2'b11, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("full_pp_level", 32'(level), 32'd8);
    chk("full_pp_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 8; i++) idle("full_drain", 1'b1);

    // Zero-flag consistency
    do_reset();
    step("zf_bad", 1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("zf_bad_set", 32'(flag_err), 32'd1);
    for (int i = 0; i < 3; i++) push_rand("zf_sticky", 1'b1);
    do_reset();
    step("zf_ok3", 1'b1, 2'b00, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("zf_ok3_clr", 32'(flag_err), 32'd0);
    do_reset();
    step("zf_ok0", 1'b1, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("zf_ok0_clr", 32'(flag_err), 32'd0);

    // Clear with a sample offered at level 5, after making drops and a flag error
    do_reset();
    step("pre_bad", 1'b1, 2'b10, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) push_rand("pre_fill", 1'b0);
    for (int i = 0; i < 3; i++) idle("pre_drain", 1'b1);
    chk("pre_level5", 32'(level), 32'd5);
    step("clear", 1'b1, 2'b01, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clear_level", 32'(level), 32'd0);
    idle("post_clear", 1'b0);

    // Asynchronous reset mid-cycle at level 3
    for (int i = 0; i < 3; i++) push_rand("ar_fill", 1'b0);
    alu_if.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all("async_hold");

`ifdef FLAG_STATS_EN
    // Flag counters: only accepted pushes count
    do_reset();
    step("st0", 1'b1, 2'b00, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("st1", 1'b1, 2'b00, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("st2", 1'b1, 2'b00, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("st3", 1'b1, 2'b00, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("st_fill", 1'b1, 2'b01, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("st_drop", 1'b1, 2'b00, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stats_carry", 32'(carry_cnt), 32'd3);
    chk("stats_ovf", 32'(ovf_cnt), 32'd1);
    chk("stats_drop", 32'(drop_cnt), 32'd1);
`endif

    // Random traffic with occasional clears and bad zero flags
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      logic       z;
      r = 4'($urandom);
      z = (r == 4'h0);
      if ($urandom_range(0, 15) == 0) z = ~z;
      step("rand", ($urandom_range(0, 3) != 0), 2'($urandom), r, 1'($urandom), z, 1'($urandom),
           (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 79) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
